// File: rtl/proc_mem_pkg.sv
// Shared types and helpers for the processor memory responder.
// Pure declarations; no state, no latency.
// No flow control here.
package proc_mem_pkg;

    typedef enum logic [1:0] {
        LOAD_HDR,
        LOAD_DATA,
        RUN
    } state_t;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    // Index is sized for the largest supported depth (65536 words).
    typedef struct packed {
        logic        vld;
        logic [15:0] idx;
    } mem_dec_t;

    // An address is usable only if it is word aligned and inside the array.
    function automatic mem_dec_t mem_decode(input logic [31:0] addr, input int unsigned nwords);
        mem_dec_t d;
        d.vld = (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < nwords);
        d.idx = addr[17:2] & 16'(nwords - 1);
        return d;
    endfunction

endpackage

// File: rtl/proc_mem_responder_mem_2r1w.sv
// Word array with two combinational read ports and one write port.
// Reads are zero latency; writes land at the rising edge.
// No backpressure: every port is accepted every cycle.
module mem_2r1w #(
    parameter int unsigned NWORDS = 256,
    parameter int          AW     = $clog2(NWORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr0,
    output logic [31:0]   rdata0,
    input  logic [AW-1:0] raddr1,
    output logic [31:0]   rdata1
);

    logic [31:0] mem [NWORDS];

    // No reset: program image must survive a core reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/proc_mem_responder.sv
// imem/dmem responder for the TinyRV1 core plus a byte-serial program loader.
// Reads are combinational (0 cycles); stores and loader words commit at the edge.
// load_rdy is high while loading and low in RUN; memory ports never stall.
module proc_mem_responder
    import proc_mem_pkg::*;
#(
    parameter int unsigned NWORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemreq_val,
    input  logic [31:0] imemreq_addr,
    output logic [31:0] imemresp_data,
    input  logic        dmemreq_val,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    output logic [31:0] dmemresp_rdata,
    input  logic        load_val,
    output logic        load_rdy,
    input  logic [7:0]  load_data,
    output logic        proc_hold,
    output logic        err
);

    localparam int AW = $clog2(NWORDS);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [23:0] byte_sr;
    logic [31:0] n_words;
    logic [31:0] word_cnt;

    logic        run;
    logic        load_xfer;
    logic        word_done;
    logic [31:0] load_word;
    logic        ld_we;
    mem_dec_t    i_dec;
    mem_dec_t    d_dec;
    logic        i_rd;
    logic        d_rd;
    logic        d_wr;
    logic        bad_req;
    logic        mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] rdata0;
    logic [31:0] rdata1;

    assign run       = (state == RUN);
    assign proc_hold = !run;
    assign load_rdy  = !run;

    assign load_xfer = load_val && load_rdy;
    assign word_done = load_xfer && (byte_cnt == 2'd3);
    assign load_word = {load_data, byte_sr};
    assign ld_we     = (state == LOAD_DATA) && word_done && (word_cnt < NWORDS);

    assign i_dec = mem_decode(imemreq_addr, NWORDS);
    assign d_dec = mem_decode(dmemreq_addr, NWORDS);

    assign i_rd    = run && imemreq_val && i_dec.vld;
    assign d_rd    = run && dmemreq_val && (dmemreq_type == MEMREQ_READ) && d_dec.vld;
    assign d_wr    = run && dmemreq_val && (dmemreq_type == MEMREQ_WRITE) && d_dec.vld;
    assign bad_req = run && ((imemreq_val && !i_dec.vld) || (dmemreq_val && !d_dec.vld));

    // Loader and dmem never write in the same cycle: they live in different states.
    assign mem_we    = ld_we || d_wr;
    assign mem_waddr = ld_we ? word_cnt[AW-1:0] : AW'(d_dec.idx);
    assign mem_wdata = ld_we ? load_word : dmemreq_wdata;

    mem_2r1w #(.NWORDS(NWORDS)) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .raddr0 (AW'(i_dec.idx)),
        .rdata0 (rdata0),
        .raddr1 (AW'(d_dec.idx)),
        .rdata1 (rdata1)
    );

    assign imemresp_data  = i_rd ? rdata0 : 32'h0;
    assign dmemresp_rdata = d_rd ? rdata1 : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= LOAD_HDR;
            byte_cnt <= 2'd0;
            byte_sr  <= 24'h0;
            n_words  <= 32'h0;
            word_cnt <= 32'h0;
            err      <= 1'b0;
        end else begin
            if (load_xfer) begin
                byte_cnt <= byte_cnt + 2'd1;
                byte_sr  <= {load_data, byte_sr[23:8]};
                if (byte_cnt == 2'd3) begin
                    case (state)
                        LOAD_HDR: begin
                            n_words  <= load_word;
                            word_cnt <= 32'h0;
                            state    <= (load_word == 32'h0) ? RUN : LOAD_DATA;
                        end
                        LOAD_DATA: begin
                            word_cnt <= word_cnt + 32'd1;
                            if (word_cnt >= NWORDS) begin
                                err <= 1'b1;
                            end
                            if (word_cnt == n_words - 32'd1) begin
                                state <= RUN;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            if (bad_req) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_proc_mem_responder.sv
// Bench for proc_mem_responder: 256- and 16-word instances share one stimulus
// stream and are compared every cycle against a byte-stream memory model.
module tb_proc_mem_responder;
    import proc_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imemreq_val = 1'b0;
    logic [31:0] imemreq_addr = 32'h0;
    logic        dmemreq_val = 1'b0;
    logic        dmemreq_type = 1'b0;
    logic [31:0] dmemreq_addr = 32'h0;
    logic [31:0] dmemreq_wdata = 32'h0;
    logic        load_val = 1'b0;
    logic [7:0]  load_data = 8'h0;

    logic [31:0] ir0, ir1, dr0, dr1;
    logic        rdy0, rdy1, hold0, hold1, err0, err1;

    always #5 clk = ~clk;

    proc_mem_responder #(.NWORDS(256)) dut (
        .clk(clk), .rst(rst),
        .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(ir0),
        .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
        .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dr0),
        .load_val(load_val), .load_rdy(rdy0), .load_data(load_data),
        .proc_hold(hold0), .err(err0)
    );

    proc_mem_responder #(.NWORDS(16)) dut16 (
        .clk(clk), .rst(rst),
        .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(ir1),
        .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
        .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dr1),
        .load_val(load_val), .load_rdy(rdy1), .load_data(load_data),
        .proc_hold(hold1), .err(err1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: a count of loader bytes seen, plus a known-value shadow array.
    int          depth [2] = '{256, 16};
    logic [31:0] mref  [2][256];
    bit          known [2][256];
    bit          m_run;
    longint      m_bytes;
    logic [31:0] m_n;
    logic [31:0] m_cur;
    bit          m_err [2];

    function automatic bit addr_ok(input logic [31:0] a, input int d);
        return ((a & 32'd3) == 32'd0) && (int'(a >> 2) < depth[d]);
    endfunction

    task automatic model_reset();
        m_run   = 1'b0;
        m_bytes = 0;
        m_cur   = 32'h0;
        m_err   = '{1'b0, 1'b0};
    endtask

    task automatic model_edge();
        longint k;
        if (!rst) return;
        if (!m_run) begin
            if (load_val) begin
                m_cur = m_cur | (32'(load_data) << (8 * (m_bytes % 4)));
                m_bytes++;
                if (m_bytes % 4 == 0) begin
                    if (m_bytes == 4) begin
                        m_n = m_cur;
                        if (m_n == 32'h0) m_run = 1'b1;
                    end else begin
                        k = m_bytes / 4 - 2;
                        for (int d = 0; d < 2; d++) begin
                            if (k < depth[d]) begin
                                mref[d][k]  = m_cur;
                                known[d][k] = 1'b1;
                            end else begin
                                m_err[d] = 1'b1;
                            end
                        end
                        if (k + 1 == longint'({32'h0, m_n})) m_run = 1'b1;
                    end
                    m_cur = 32'h0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if ((imemreq_val && !addr_ok(imemreq_addr, d)) ||
                    (dmemreq_val && !addr_ok(dmemreq_addr, d)))
                    m_err[d] = 1'b1;
                if (dmemreq_val && dmemreq_type == MEMREQ_WRITE && addr_ok(dmemreq_addr, d)) begin
                    mref[d][dmemreq_addr >> 2]  = dmemreq_wdata;
                    known[d][dmemreq_addr >> 2] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [31:0] get_out(input int d, input int which);
        case (which)
            0: return 32'(d == 0 ? hold0 : hold1);
            1: return 32'(d == 0 ? rdy0 : rdy1);
            2: return 32'(d == 0 ? err0 : err1);
            3: return d == 0 ? ir0 : ir1;
            default: return d == 0 ? dr0 : dr1;
        endcase
    endfunction

    task automatic check_read(input string tag, input int d, input bit v, input logic [31:0] a,
                              input logic [31:0] got);
        if (m_run && v && addr_ok(a, d)) begin
            if (known[d][a >> 2]) check(tag, got, mref[d][a >> 2]);
        end else begin
            check(tag, got, 32'h0);
        end
    endtask

    task automatic tick();
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("hold%0d", d), get_out(d, 0), 32'(!m_run));
            check($sformatf("rdy%0d", d),  get_out(d, 1), 32'(!m_run));
            check($sformatf("err%0d", d),  get_out(d, 2), 32'(m_err[d]));
            check_read($sformatf("imem%0d@%h", d, imemreq_addr), d, imemreq_val,
                       imemreq_addr, get_out(d, 3));
            check_read($sformatf("dmem%0d@%h", d, dmemreq_addr), d,
                       dmemreq_val && dmemreq_type == MEMREQ_READ, dmemreq_addr, get_out(d, 4));
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic req_idle();
        imemreq_val = 1'b0;
        dmemreq_val = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 32'($urandom_range(0, 31)) * 4;
        if (r == 6) return 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
        if (r == 7) return ($urandom_range(0, 1) != 0) ? 32'h3FC : 32'h400;
        if (r == 8) return $urandom;
        return 32'h44;
    endfunction

    task automatic rand_req();
        imemreq_val   = 1'($urandom_range(0, 1));
        imemreq_addr  = rand_addr();
        dmemreq_val   = 1'($urandom_range(0, 1));
        dmemreq_type  = 1'($urandom_range(0, 1));
        dmemreq_addr  = rand_addr();
        dmemreq_wdata = $urandom;
    endtask

    // Random memory traffic rides alongside every loader byte; it must be ignored.
    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) begin
            load_val  = 1'b0;
            load_data = 8'($urandom);
            rand_req();
            tick();
        end
        load_val  = 1'b1;
        load_data = b;
        rand_req();
        tick();
        load_val  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_reset();
        load_val = 1'b0;
        req_idle();
        rst = 1'b0;
        #1;
        check("async_hold0", 32'(hold0), 32'h1);
        check("async_hold1", 32'(hold1), 32'h1);
        model_reset();
        tick();
        rst = 1'b1;
    endtask

    task automatic sweep();
        for (int i = 0; i < 36; i++) begin
            imemreq_val  = 1'b1;
            imemreq_addr = 32'(i) * 4;
            dmemreq_val  = 1'b1;
            dmemreq_type = MEMREQ_READ;
            dmemreq_addr = 32'(35 - i) * 4;
            tick();
        end
        req_idle();
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) known[d][i] = 1'b0;
        model_reset();
        @(negedge clk);

        // Basic two-word program
        do_reset();
        send_word(32'd2);
        send_word(32'h00100513);
        send_word(32'h00200593);
        req_idle();
        #1;
        check("hold_fall", 32'(hold0), 32'h0);
        imemreq_val  = 1'b1;
        imemreq_addr = 32'h4;
        #1;
        check("imem4", ir0, 32'h00200593);
        tick();

        // Same-cycle store and fetch return the old word
        imemreq_val   = 1'b0;
        dmemreq_val   = 1'b1;
        dmemreq_type  = MEMREQ_WRITE;
        dmemreq_addr  = 32'h40;
        dmemreq_wdata = 32'h11111111;
        tick();
        dmemreq_wdata = 32'hDEADBEEF;
        imemreq_val   = 1'b1;
        imemreq_addr  = 32'h40;
        #1;
        check("rw_old", ir0, 32'h11111111);
        tick();
        dmemreq_val = 1'b0;
        #1;
        check("rw_new", ir0, 32'hDEADBEEF);
        check("rw16_inv", ir1, 32'h0);
        tick();
        imemreq_addr = 32'h44;
        tick();
        imemreq_val   = 1'b0;
        dmemreq_val   = 1'b1;
        dmemreq_type  = MEMREQ_WRITE;
        dmemreq_addr  = 32'h2;
        dmemreq_wdata = 32'h55555555;
        tick();
        req_idle();
        #1;
        check("err16_sticky", 32'(err1), 32'h1);
        tick();

        repeat (300) begin
            rand_req();
            tick();
        end

        // Overflowing load into the 16-word instance
        do_reset();
        send_word(32'd17);
        for (int i = 0; i < 17; i++) send_word($urandom);
        req_idle();
        #1;
        check("ovf_err16", 32'(err1), 32'h1);
        check("ovf_err256", 32'(err0), 32'h0);
        check("ovf_hold16", 32'(hold1), 32'h0);
        sweep();

        // Reset in the middle of a load
        do_reset();
        send_word(32'd3);
        send_byte(8'hAA);
        send_byte(8'hBB);
        do_reset();
        #1;
        check("abort_rdy", 32'(rdy0), 32'h1);
        check("abort_hold", 32'(hold1), 32'h1);
        send_word(32'd1);
        send_word(32'hCAFEF00D);
        req_idle();
        sweep();

        // Empty image
        do_reset();
        send_word(32'd0);
        req_idle();
        #1;
        check("empty_rdy", 32'(rdy0), 32'h0);
        check("empty_hold", 32'(hold1), 32'h0);
        sweep();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
